present_cipher_core: RTL

Iterative PRESENT block cipher core that performs both encryption and decryption on 64-bit blocks, with 80-bit or 128-bit keys selected at elaboration time. Each block computes its round keys on the fly, one per cycle, so no table of precomputed round keys is needed. Blocks enter and leave through valid/ready handshakes, so the core sits directly between the crypto front-end and the block buffers.

---
 rtl/present_cipher_core_pkg.sv | 79 +++++++
 rtl/present_cipher_core_if.sv | 30 +++
 rtl/present_key_step.sv | 41 ++++
 rtl/present_cipher_core.sv | 120 ++++++++++++
 4 files changed

// File: rtl/present_cipher_core_pkg.sv
// present_pkg: shared definitions for the PRESENT cipher core.
//   BLOCK_SIZE / DEFAULT_NUM_ROUNDS : block width and default round count
//   mode_e                          : ENCRYPT / DECRYPT
//   fsm_state_e, dbg_t              : core FSM encoding and debug view
//   sbox / inv_sbox                 : 4-bit S-box and its inverse
//   s_layer / inv_s_layer           : S-box applied to all 16 nibbles
//   p_layer / inv_p_layer           : bit i -> 16*i mod 63, bit 63 fixed
package present_pkg;

    localparam int BLOCK_SIZE         = 64;
    localparam int DEFAULT_NUM_ROUNDS = 31;

    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ROUND  = 3'd2,
        FINAL  = 3'd3,
        DONE   = 3'd4
    } fsm_state_e;

    typedef struct packed {
        fsm_state_e  state;
        logic [4:0]  round_ctr;
    } dbg_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
            4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
            4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// present_cipher_core_if: request/response bus of the PRESENT core.
//   master : drives in_valid, mode, key, data_in, out_ready
//   slave  : drives in_ready, out_valid, data_out, busy
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The request side (in_*) samples mode/key/data_in only on that
// edge. The response side holds out_valid and data_out unchanged until the
// edge where out_ready is also high; out_valid never drops without it.
interface present_cipher_core_if #(
    parameter int KEY_SIZE = 80
);
    logic                                in_valid;
    logic                                in_ready;
    logic                                mode;
    logic [KEY_SIZE-1:0]                 key;
    logic [present_pkg::BLOCK_SIZE-1:0]  data_in;
    logic                                out_valid;
    logic                                out_ready;
    logic [present_pkg::BLOCK_SIZE-1:0]  data_out;
    logic                                busy;

    modport master (
        output in_valid, mode, key, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, mode, key, data_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/present_key_step.sv
// present_key_step: one PRESENT key-schedule step, combinational.
//   key_in  : current round key register
//   ctr     : round counter XORed into the key
//   dir     : 0 = forward step (K(i) -> K(i+1)), 1 = inverse step
//   key_out : next (or previous) key register value
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_SIZE = 80
) (
    input  logic [KEY_SIZE-1:0] key_in,
    input  logic [4:0]          ctr,
    input  logic                dir,
    output logic [KEY_SIZE-1:0] key_out
);
    localparam int CTR_LSB  = (KEY_SIZE == 128) ? 62 : 15;
    // Second S-boxed nibble only exists for 128-bit keys; for 80 bits the
    // index aliases the top nibble but is never used.
    localparam int NIB2_LSB = (KEY_SIZE == 128) ? 120 : KEY_SIZE - 4;

    logic [KEY_SIZE-1:0] fwd_k;
    logic [KEY_SIZE-1:0] inv_t;
    logic [KEY_SIZE-1:0] inv_k;

    always_comb begin
        // forward: rotate left 61, S-box, XOR counter
        fwd_k = {key_in[KEY_SIZE-62:0], key_in[KEY_SIZE-1:KEY_SIZE-61]};
        fwd_k[KEY_SIZE-1 -: 4] = sbox(fwd_k[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) fwd_k[NIB2_LSB +: 4] = sbox(fwd_k[NIB2_LSB +: 4]);
        fwd_k[CTR_LSB +: 5] = fwd_k[CTR_LSB +: 5] ^ ctr;

        // inverse: XOR counter, inverse S-box, rotate right 61
        inv_t = key_in;
        inv_t[CTR_LSB +: 5] = inv_t[CTR_LSB +: 5] ^ ctr;
        inv_t[KEY_SIZE-1 -: 4] = inv_sbox(inv_t[KEY_SIZE-1 -: 4]);
        if (KEY_SIZE == 128) inv_t[NIB2_LSB +: 4] = inv_sbox(inv_t[NIB2_LSB +: 4]);
        inv_k = {inv_t[60:0], inv_t[KEY_SIZE-1:61]};

        key_out = dir ? inv_k : fwd_k;
    end
endmodule

// File: rtl/present_cipher_core.sv
// present_cipher_core: iterative PRESENT encrypt/decrypt, one round per clock.
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : request/response handshake (slave modport)
//   dbg   : FSM state and round counter for observation
// Encrypt walks K1..K32 forward; decrypt first expands to K32 (KEYEXP) then
// walks the schedule backwards with the inverse key step during ROUND.
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_SIZE   = 80,
    parameter int NUM_ROUNDS = DEFAULT_NUM_ROUNDS
) (
    input  logic                   Clock,
    input  logic                   Reset,
    present_cipher_core_if.slave   bus,
    output dbg_t                   dbg
);
    if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
        $error("present_cipher_core: KEY_SIZE must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("present_cipher_core: NUM_ROUNDS must be 1..31");
    end

    localparam logic [4:0] LAST_CTR = 5'(NUM_ROUNDS);

    fsm_state_e           state_q;
    mode_e                mode_q;
    logic [63:0]          state_reg;
    logic [KEY_SIZE-1:0]  key_reg;
    logic [4:0]           round_ctr;
    logic [63:0]          data_out_q;
    logic                 out_valid_q;

    logic [KEY_SIZE-1:0]  key_next;
    logic [63:0]          round_key;
    logic [63:0]          enc_next;
    logic [63:0]          dec_next;
    logic                 key_dir;

    // The round key is always the leftmost 64 bits of the key register.
    assign round_key = key_reg[KEY_SIZE-1 -: 64];
    assign enc_next  = p_layer(s_layer(state_reg ^ round_key));
    assign dec_next  = inv_s_layer(inv_p_layer(state_reg ^ round_key));
    // Only decrypt rounds step the schedule backwards; KEYEXP steps forward.
    assign key_dir   = (state_q == ROUND) && (mode_q == DECRYPT);

    present_key_step #(.KEY_SIZE(KEY_SIZE)) u_key_step (
        .key_in  (key_reg),
        .ctr     (round_ctr),
        .dir     (key_dir),
        .key_out (key_next)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mode_q      <= ENCRYPT;
            state_reg   <= '0;
            key_reg     <= '0;
            round_ctr   <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.data_in;
                        key_reg   <= bus.key;
                        round_ctr <= 5'd1;
                        mode_q    <= mode_e'(bus.mode);
                        state_q   <= (mode_e'(bus.mode) == DECRYPT) ? KEYEXP : ROUND;
                    end
                end
                KEYEXP: begin
                    key_reg <= key_next;
                    if (round_ctr == LAST_CTR) begin
                        // key_reg now holds K(NUM_ROUNDS+1); start decrypting from it
                        state_q <= ROUND;
                    end else begin
                        round_ctr <= round_ctr + 5'd1;
                    end
                end
                ROUND: begin
                    key_reg <= key_next;
                    if (mode_q == ENCRYPT) begin
                        state_reg <= enc_next;
                        if (round_ctr == LAST_CTR) state_q <= FINAL;
                        else                       round_ctr <= round_ctr + 5'd1;
                    end else begin
                        state_reg <= dec_next;
                        round_ctr <= round_ctr - 5'd1;
                        if (round_ctr == 5'd1) state_q <= FINAL;
                    end
                end
                FINAL: begin
                    data_out_q  <= state_reg ^ round_key;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;

    assign dbg.state     = state_q;
    assign dbg.round_ctr = round_ctr;
endmodule
